// File: rtl/load_store_unit.sv
// Load/store unit: turns one MEM-stage load or store into a single
// req/gnt/rvalid transaction on a word-addressed data bus, generates byte
// enables and lane-replicated store data, and extends returned load data.
module load_store_unit #(
    parameter int XLEN = 32,
    parameter int BE_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            rdata_valid_o,
    output logic            misaligned_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [BE_W-1:0] bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            req, is_load, f3_legal, aligned, fault, accept;
    logic [BE_W-1:0] be_d;
    logic [XLEN-1:0] wdata_d;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_ext;

    // Decode the incoming request: legality, alignment, byte enables and store lanes
    always_comb begin
        req      = mem_read_i | mem_write_i;
        is_load  = mem_read_i;
        f3_legal = 1'b0;
        aligned  = 1'b0;
        be_d     = '1;
        wdata_d  = wdata_i;
        if (is_load) begin
            f3_legal = (funct3_i[1:0] != 2'b11) && !(funct3_i[2] && funct3_i[1]);
        end else begin
            f3_legal = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
        end
        case (funct3_i[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                aligned = ~addr_i[0];
                be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                aligned = (addr_i[1:0] == 2'b00);
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
        fault  = req & ~(f3_legal & aligned);
        accept = req & f3_legal & aligned;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus combinational stall and fault flags
    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        case (state_q)
            IDLE: begin
                misaligned_o = fault;
                stall_o      = accept;
                if (accept) state_d = REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                if (bus_gnt_i) state_d = bus_we_o ? DONE : WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) state_d = DONE;
            end
            DONE: begin
                // mem_*_i still carry the instruction just completed
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            stall_o      = 1'b0;
            misaligned_o = 1'b0;
        end
    end

    // Select the addressed lane of the returned word and extend it
    always_comb begin
        shifted  = bus_rdata_i >> {lane_q, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{24{1'b0}}, byte_sel};
            3'b101:  load_ext = {{16{1'b0}}, half_sel};
            default: load_ext = bus_rdata_i;
        endcase
    end

    // Registered bus outputs, access attributes and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_be_o      <= '0;
            bus_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            f3_q          <= '0;
            lane_q        <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= ~is_load;
                        bus_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                        bus_be_o    <= be_d;
                        bus_wdata_o <= is_load ? '0 : wdata_d;
                        f3_q        <= funct3_i;
                        lane_q      <= addr_i[1:0];
                    end
                end
                REQ: begin
                    if (bus_gnt_i) bus_req_o <= 1'b0;
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        rdata_o       <= load_ext;
                        rdata_valid_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores compared against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misaligned_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .BE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misaligned_o(misaligned_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        bit ok;
        sz = int'(f3[1:0]);
        if (sz == 3) return 1'b0;
        if (ld) ok = !(f3[2] && sz == 2);
        else    ok = !f3[2];
        if ((int'(a[1:0]) % (1 << sz)) != 0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        case (int'(f3[1:0]))
            0:       return 4'(1 << int'(a[1:0]));
            1:       return 4'(3 << int'(a[1:0]));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (int'(f3[1:0]))
            0:       return (wd % 256) * 32'h01010101;
            1:       return (wd % 65536) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = d >> (8 * int'(a[1:0]));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = d;
        endcase
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat,
                           input int gdly, input int rdly, input string nm);
        bit ld;
        bit legal;
        int stalls;
        ld     = rd;
        legal  = m_legal(ld, f3, a);
        stalls = 0;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(negedge clk);
        check({nm, "/misaligned"}, 32'(misaligned_o), 32'(!legal));
        check({nm, "/stall_idle"}, 32'(stall_o), 32'(legal));
        if (!legal) begin
            check({nm, "/no_req"}, 32'(bus_req_o), 0);
            @(posedge clk); #1;
            mem_read_i = 1'b0; mem_write_i = 1'b0;
            @(negedge clk);
            check({nm, "/no_req_after"}, 32'(bus_req_o), 0);
            check({nm, "/no_stall_after"}, 32'(stall_o), 0);
            @(posedge clk); #1;
            return;
        end
        stalls = 1;
        @(posedge clk); #1;
        for (int c = 0; c <= gdly; c++) begin
            @(negedge clk);
            stalls += int'(stall_o);
            check({nm, "/req"},   32'(bus_req_o), 1);
            check({nm, "/addr"},  bus_addr_o, a & 32'hFFFFFFFC);
            check({nm, "/be"},    32'(bus_be_o), 32'(m_be(f3, a)));
            check({nm, "/we"},    32'(bus_we_o), 32'(!ld));
            check({nm, "/wdata"}, bus_wdata_o, ld ? 32'h0 : m_wdata(f3, wd));
            bus_gnt_i = (c == gdly);
            @(posedge clk); #1;
            bus_gnt_i = 1'b0;
        end
        if (ld) begin
            for (int c = 0; c <= rdly; c++) begin
                @(negedge clk);
                stalls += int'(stall_o);
                check({nm, "/req_dropped"}, 32'(bus_req_o), 0);
                if (c == rdly) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = rdat;
                end
                @(posedge clk); #1;
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = $urandom;
            end
            last_rdata = m_load(f3, a, rdat);
        end
        @(negedge clk);
        check({nm, "/stall_done"}, 32'(stall_o), 0);
        check({nm, "/rvalid_done"}, 32'(rdata_valid_o), 32'(ld));
        check({nm, "/rdata"}, rdata_o, last_rdata);
        check({nm, "/stall_cycles"}, 32'(stalls), 32'(2 + gdly + (ld ? rdly + 1 : 0)));
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        @(negedge clk);
        check({nm, "/idle_req"}, 32'(bus_req_o), 0);
        check({nm, "/idle_rvalid"}, 32'(rdata_valid_o), 0);
        check({nm, "/rdata_held"}, rdata_o, last_rdata);
        @(posedge clk); #1;
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "/req"},    32'(bus_req_o), 0);
        check({nm, "/we"},     32'(bus_we_o), 0);
        check({nm, "/addr"},   bus_addr_o, 0);
        check({nm, "/be"},     32'(bus_be_o), 0);
        check({nm, "/wdata"},  bus_wdata_o, 0);
        check({nm, "/rdata"},  rdata_o, 0);
        check({nm, "/rvalid"}, 32'(rdata_valid_o), 0);
        check({nm, "/stall"},  32'(stall_o), 0);
        check({nm, "/misal"},  32'(misaligned_o), 0);
    endtask

    // Abandon an LW in REQ or WAIT with an asynchronous reset
    task automatic reset_mid(input bit in_wait, input string nm);
        mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h8;
        @(posedge clk); #1;
        if (in_wait) begin
            @(negedge clk); bus_gnt_i = 1'b1;
            @(posedge clk); #1; bus_gnt_i = 1'b0;
        end
        check({nm, "/req_before"}, 32'(bus_req_o), 32'(!in_wait));
        funct3_i = 3'b011;
        rst_n = 1'b0;
        #1;
        check_cleared({nm, "/in_reset"});
        @(negedge clk);
        bus_rvalid_i = 1'b1; bus_gnt_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        check_cleared({nm, "/reset_pulse"});
        mem_read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = '0;
        bus_rvalid_i = 1'b1; bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        @(negedge clk);
        check_cleared({nm, "/after_release"});
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst_n = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        #12;
        check_cleared("por");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, "lw_100");
        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, "lb_103");
        run_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, "lbu_103");
        run_txn(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, "sh_102");
        run_txn(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, "lw_misal");
        run_txn(1, 0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, "ld_f3_011");
        run_txn(0, 1, 3'b100, 32'h000, 32'h55, 32'h0, 0, 0, "st_f3_100");
        run_txn(1, 0, 3'b001, 32'h002, 32'h0, 32'h80015555, 0, 0, "lh_002");
        run_txn(1, 0, 3'b101, 32'h000, 32'h0, 32'h12348001, 0, 0, "lhu_000");
        run_txn(1, 1, 3'b000, 32'h001, 32'hFFFFFFFF, 32'h00007F00, 1, 1, "both_is_load");

        reset_mid(1'b1, "rst_wait");
        run_txn(1, 0, 3'b010, 32'h4, 32'h0, 32'h13579BDF, 0, 0, "lw_4_after_rst");
        reset_mid(1'b0, "rst_req");
        run_txn(0, 1, 3'b010, 32'h40, 32'h89ABCDEF, 32'h0, 1, 0, "sw_after_rst");

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mem_read_i = 1'b0; mem_write_i = 1'b0;
                funct3_i = 3'($urandom); addr_i = $urandom;
                @(negedge clk);
                check("rand_idle/stall", 32'(stall_o), 0);
                check("rand_idle/misal", 32'(misaligned_o), 0);
                check("rand_idle/req", 32'(bus_req_o), 0);
                @(posedge clk); #1;
            end
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (rd) f3 = load_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            run_txn(rd, wr, f3, a, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage responder to the load/store controls (mem_read, mem_write, funct3) that the main decoder issues. Each load or store is turned into one transaction on a word-addressed data bus with a req/gnt/rvalid handshake. Byte enables and store-lane replication are generated, and load data is extracted and sign- or zero-extended. The pipeline is held via stall_o until the access completes.

Parameters:
XLEN, 32, data/address width (only 32 supported)
BE_W, 4, byte-enable width (XLEN/8)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
mem_read_i  input  1  load request from MEM stage
mem_write_i  input  1  store request from MEM stage
funct3_i  input  3  access width/signedness (RV32I load/store funct3)
addr_i  input  XLEN  byte address (ALU result)
wdata_i  input  XLEN  store data (rs2)
stall_o  output  1  hold pipeline
rdata_o  output  XLEN  extended load result
rdata_valid_o  output  1  one-cycle pulse, load result valid
misaligned_o  output  1  misaligned address or illegal funct3
bus_req_o  output  1  bus request
bus_we_o  output  1  1=write
bus_addr_o  output  XLEN  word-aligned address, addr_i with [1:0] forced to 0
bus_be_o  output  BE_W  byte enables
bus_wdata_o  output  XLEN  lane-replicated store data
bus_gnt_i  input  1  request accepted this cycle
bus_rvalid_i  input  1  read data valid
bus_rdata_i  input  XLEN  read data

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous and active-low. Reset forces state IDLE and clears all registered outputs: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_o, rdata_valid_o. stall_o and misaligned_o read 0 while in reset.
- Request: mem_read_i or mem_write_i high. If both are high, it is treated as a load.
- Legality:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other load funct3 is illegal.
  - Stores: funct3 000 SB, 001 SH, 010 SW. Any other store funct3 is illegal.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Fault: in IDLE, an illegal or misaligned request gives combinational misaligned_o=1 in that cycle. stall_o=0, no bus activity, state stays IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: a legal request makes stall_o=1 combinationally. Next edge registers addr/be/wdata/we/width/sign, asserts bus_req_o and moves to REQ.
  - REQ: bus_req_o and all bus_* outputs stay stable until bus_gnt_i=1. On gnt: a store goes to DONE, a load goes to WAIT. stall_o=1.
  - WAIT: stall_o=1. On bus_rvalid_i, extract and extend the lane, register it into rdata_o and go to DONE. The bus guarantees rvalid no earlier than the cycle after gnt; rvalid seen outside WAIT is ignored.
  - DONE: stall_o=0 and rdata_valid_o=1 (loads only). mem_*_i inputs are ignored this cycle because they still carry the same instruction. Next state is IDLE.
- Timing: with gnt and rvalid at the earliest possible cycles, a load stalls 3 cycles and a store stalls 2.
- Byte enables and store data:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 if addr[1]=0, else 1100; wdata = halfword replicated x2.
  - SW: be = 1111.
  - Loads drive the same be pattern, with bus_we_o=0 and bus_wdata_o=0.
- Load extract: lane selected by the registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rdata_o holds its value until the next load completes.
- Reset mid-transaction: the transaction is abandoned and bus_req_o drops immediately. Any later gnt or rvalid is ignored.

Test Plan:
- LW 0x100; gnt low 2 cycles then high; rvalid 0xDEADBEEF the next cycle -> bus_addr_o=0x100, be=1111, we=0. stall_o high exactly 5 cycles. In DONE, rdata_o=0xDEADBEEF with rdata_valid_o pulsed once.
- LB 0x103, bus_rdata=0x80123456, gnt/rvalid at the earliest cycles -> be=1000, rdata_o=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH 0x102, wdata_i=0x1234ABCD, immediate gnt -> be=1100, bus_wdata_o=0xABCDABCD, we=1. stall_o high 2 cycles, no rdata_valid_o.
- LW 0x102; then funct3=011 load at 0x0; then SB with funct3=100 -> misaligned_o=1 in the same cycle each time. stall_o=0, bus_req_o never asserted.
- LH 0x002, rdata=0x8001xxxx -> rdata_o=0xFFFF8001. LHU 0x000 with rdata=0xxxxx8001 -> rdata_o=0x00008001.
- rst_n low during WAIT, rvalid pulsed during reset -> bus_req_o=0, rdata_valid_o stays 0. After release, LW 0x4 completes normally.
